// File: rtl/pc_seq_pkg.sv
// Shared defaults and helpers for the multi-thread PC sequencer.
// Optional link-register capture is enabled by defining PC_LINK_EN.
package pc_seq_pkg;

    localparam int PC_WIDTH_D    = 9;
    localparam int NUM_THREADS_D = 4;
    localparam int RESET_PC_D    = 0;

    // Thread-id width; a single thread still needs one bit of id.
    function automatic int tid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_thread_arbiter.sv
// Combinational round-robin pick of the next active thread.
// The current thread is searched last so every active thread gets a turn.
module rr_thread_arbiter
    import pc_seq_pkg::*;
#(
    parameter int NUM_THREADS = NUM_THREADS_D,
    localparam int TID_W      = tid_w(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0] i_thread_en,
    input  logic [TID_W-1:0]       i_cur,
    output logic [TID_W-1:0]       o_nxt,
    output logic                   o_any
);

    // Scan from farthest to nearest offset so the nearest active thread wins.
    always_comb begin
        o_nxt = i_cur;
        o_any = 1'b0;
        for (int k = NUM_THREADS; k >= 1; k--) begin
            if (i_thread_en[TID_W'((int'(i_cur) + k) % NUM_THREADS)]) begin
                o_nxt = TID_W'((int'(i_cur) + k) % NUM_THREADS);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-thread PC sequencer: one (thread, PC) fetch per cycle, round-robin.
// Define PC_LINK_EN to capture link registers on branches.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_D,
    parameter int NUM_THREADS = NUM_THREADS_D,
    parameter int RESET_PC    = RESET_PC_D,
    localparam int TID_W      = tid_w(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   stall,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic                   br_valid,
    input  logic [TID_W-1:0]       br_thread,
    input  logic [PC_WIDTH-1:0]    br_target,
    input  logic                   br_link,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [TID_W-1:0]       thread_id,
    output logic                   pc_valid,
    output logic [PC_WIDTH-1:0]    lr_out
);

    logic [PC_WIDTH-1:0] r_pc [NUM_THREADS];
    logic [TID_W-1:0]    r_cur;
    logic [PC_WIDTH-1:0] r_pc_out;
    logic [TID_W-1:0]    r_tid;
    logic                r_valid;

    logic [TID_W-1:0]    w_nxt;
    logic                w_any;
    logic                w_issue;
    logic                w_br_ok;
    logic                w_bypass;
    logic [PC_WIDTH-1:0] w_issue_pc;

    rr_thread_arbiter #(
        .NUM_THREADS (NUM_THREADS)
    ) u_arb (
        .i_thread_en (thread_en),
        .i_cur       (r_cur),
        .o_nxt       (w_nxt),
        .o_any       (w_any)
    );

    assign w_issue    = en && !stall && w_any;
    assign w_br_ok    = br_valid && (int'(br_thread) < NUM_THREADS);
    assign w_bypass   = w_issue && w_br_ok && (br_thread == w_nxt);
    assign w_issue_pc = w_bypass ? br_target : r_pc[w_nxt];

    // Branch redirect every cycle, then issue overrides the selected thread.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_pc[t] <= PC_WIDTH'(RESET_PC);
            end
            r_cur    <= TID_W'(NUM_THREADS - 1);
            r_pc_out <= PC_WIDTH'(RESET_PC);
            r_tid    <= '0;
            r_valid  <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (w_br_ok && br_thread == TID_W'(t)) begin
                    r_pc[t] <= br_target;
                end
            end
            if (w_issue) begin
                r_pc[w_nxt] <= w_issue_pc + 1'b1;
                r_cur       <= w_nxt;
                r_pc_out    <= w_issue_pc;
                r_tid       <= w_nxt;
                r_valid     <= 1'b1;
            end else if (!stall) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pc_out    = r_pc_out;
    assign thread_id = r_tid;
    assign pc_valid  = r_valid;

`ifdef PC_LINK_EN
    logic [PC_WIDTH-1:0] r_lr [NUM_THREADS];
    logic [PC_WIDTH-1:0] r_lr_out;

    // Capture the pre-redirect PC as link; bypass it when issued same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_lr[t] <= '0;
            end
            r_lr_out <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (w_br_ok && br_link && br_thread == TID_W'(t)) begin
                    r_lr[t] <= r_pc[t];
                end
            end
            if (w_issue) begin
                r_lr_out <= (w_bypass && br_link) ? r_pc[w_nxt] : r_lr[w_nxt];
            end
        end
    end

    assign lr_out = r_lr_out;
`else
    logic w_unused_link;

    assign w_unused_link = br_link;
    assign lr_out        = '0;
`endif

endmodule
